// File: rtl/lab_vector_checker.sv
// Exhaustive truth-table checker: walks every input vector of a combinational DUT,
// samples its output after a settle window and tallies mismatches against EXPECT.
module lab_vector_checker #(
  parameter int                   N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 8'hFE,
  parameter int                   SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail
);

  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t          state, state_nx;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic            settle_end, last_vec, mismatch;

  assign settle_end = (cnt == CW'(SETTLE - 1));
  assign last_vec   = (idx == N_IN'(NV - 1));
  assign mismatch   = (dut_f != EXPECT[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_SETTLE;
      S_SETTLE:       if (settle_end) state_nx = S_SAMPLE;
      S_SAMPLE:       state_nx = last_vec ? S_DONE : S_SETTLE;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Index doubles as the driven vector, so vec_out updates on the same edge as idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      cnt        <= '0;
      err_count  <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          idx        <= '0;
          cnt        <= '0;
          err_count  <= '0;
          fail_seen  <= 1'b0;
          first_fail <= '0;
        end
        S_SETTLE: cnt <= settle_end ? '0 : cnt + 1'b1;
        S_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!fail_seen) begin
              first_fail <= idx;
              fail_seen  <= 1'b1;
            end
          end
          if (!last_vec) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign vec_out = idx;
  assign busy    = (state == S_SETTLE) || (state == S_SAMPLE);
  assign done    = (state == S_DONE);
  assign pass    = done && (err_count == '0);

endmodule

// File: tb/tb_lab_vector_checker.sv
// Bench for lab_vector_checker: two instances (SETTLE=1 and SETTLE=3) driven by
// truth-table-defined fake DUTs, checked cycle by cycle against a simple model.
module tb_lab_vector_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]      start, dut_f, busy, done, pass, fail_seen;
  logic [1:0][2:0] vec_out, first_fail;
  logic [1:0][3:0] err_count;
  logic [1:0][7:0] tt;

  // Fake DUT: output is the truth-table bit selected by the driven vector
  always_comb begin
    dut_f[0] = tt[0][vec_out[0]];
    dut_f[1] = tt[1][vec_out[1]];
  end

  lab_vector_checker dut (
    .clk(clk), .rst(rst), .start(start[0]), .vec_out(vec_out[0]), .dut_f(dut_f[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .fail_seen(fail_seen[0]), .first_fail(first_fail[0])
  );

  lab_vector_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start[1]), .vec_out(vec_out[1]), .dut_f(dut_f[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .fail_seen(fail_seen[1]), .first_fail(first_fail[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: mismatch set is table XOR expectation; count and lowest index
  function automatic void model(input logic [7:0] t, output int e, output int f);
    logic [7:0] m;
    m = t ^ 8'hFE;
    e = 0;
    f = 0;
    for (int i = 7; i >= 0; i--) if (m[i]) begin e++; f = i; end
  endfunction

  // One full run on instance s; pulse_k>0 re-asserts start during that busy cycle
  task automatic run(input int s, input logic [7:0] t, input int e, input int f,
                     input int pulse_k);
    int per, n;
    per = (s == 1) ? 4 : 2;
    n   = 8 * per;
    tt[s] = t;
    @(negedge clk);
    start[s] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= n + 1; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      start[s] = 1'b0;
      if (k <= n) begin
        chk("busy_during_run", int'(busy[s]), 1);
        chk("done_during_run", int'(done[s]), 0);
        chk("vec_out_step", int'(vec_out[s]), (k - 1) / per);
      end
      if (k == 1) begin
        chk("err_cleared_on_start", int'(err_count[s]), 0);
        chk("fail_seen_cleared_on_start", int'(fail_seen[s]), 0);
      end
      if (k == pulse_k) start[s] = 1'b1;
    end
    chk("done_at_end", int'(done[s]), 1);
    chk("busy_at_end", int'(busy[s]), 0);
    chk("err_count", int'(err_count[s]), e);
    chk("fail_seen", int'(fail_seen[s]), (e > 0) ? 1 : 0);
    if (e > 0) chk("first_fail", int'(first_fail[s]), f);
    chk("pass", int'(pass[s]), (e == 0) ? 1 : 0);
    chk("vec_out_last", int'(vec_out[s]), 7);
    repeat (3) @(posedge clk);
    #1;
    chk("done_holds", int'(done[s]), 1);
    chk("err_holds", int'(err_count[s]), e);
  endtask

  typedef struct {
    logic [7:0] t;
    int         e;
    int         f;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int e, f;
    logic [7:0] r;
    tbl[0] = '{8'hFE, 0, 0};  // correct OR
    tbl[1] = '{8'h00, 7, 1};  // stuck-at-0
    tbl[2] = '{8'h80, 6, 1};  // AND instead of OR; also a restart from err=7
    tbl[3] = '{8'hFF, 1, 0};  // stuck-at-1
    tbl[4] = '{8'h7E, 1, 7};  // only the last vector wrong
    tbl[5] = '{8'h01, 8, 0};  // every vector wrong: full-scale count

    rst = 1'b1;
    start = '0;
    tt = '0;
    #12;
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_pass", int'(pass[0]), 0);
    chk("rst_err", int'(err_count[0]), 0);
    chk("rst_vec", int'(vec_out[0]), 0);
    chk("rst_fail_seen", int'(fail_seen[0]), 0);
    chk("rst_busy3", int'(busy[1]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy[0]), 0);

    for (int i = 0; i < 6; i++) run(0, tbl[i].t, tbl[i].e, tbl[i].f, 0);

    // start during vector 3 must not disturb the run
    run(0, 8'hFE, 0, 0, 7);
    run(0, 8'h00, 7, 1, 8);

    // asynchronous reset while vector 4 is on the bus
    tt[0] = 8'h00;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_reset_vec", int'(vec_out[0]), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy[0]), 0);
    chk("async_rst_vec", int'(vec_out[0]), 0);
    chk("async_rst_err", int'(err_count[0]), 0);
    chk("async_rst_fail_seen", int'(fail_seen[0]), 0);
    chk("async_rst_first", int'(first_fail[0]), 0);
    chk("async_rst_done", int'(done[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 8'hFE, 0, 0, 0);

    // longer settle window
    run(1, 8'hFE, 0, 0, 0);
    run(1, 8'h00, 7, 1, 0);

    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom);
      model(r, e, f);
      run(i % 2, r, e, f, (i == 3) ? 5 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
